// File: rtl/wb_stage_multi_pkg.sv
// Shared width helpers for the multi-lane writeback stage and its trace FIFO.
package wb_stage_multi_pkg;

  // Width of one MEM->WB lane: {lane_valid, w_en, pc, w_data, w_addr}
  function automatic int lane_wd(input int data_w, input int addr_w);
    return 2 + 2 * data_w + addr_w;
  endfunction

  // Width of one WB->RF lane: {byp_valid, rf_we, w_data, w_addr}
  function automatic int rf_lane_wd(input int data_w, input int addr_w);
    return 2 + data_w + addr_w;
  endfunction

  // Width of one trace entry: {w_en, pc, w_data, w_addr} (a lane minus lane_valid)
  function automatic int trace_wd(input int data_w, input int addr_w);
    return 1 + 2 * data_w + addr_w;
  endfunction

  localparam int DEBUG_WEN_W = 4;

endpackage

// File: rtl/wb_stage_multi_trace.sv
// Trace FIFO: up to LANES pushes per cycle compacted in lane order, one pop per
// cycle. DEPTH must be a power of two so the pointers wrap by truncation.
module wb_trace_fifo
  import wb_stage_multi_pkg::*;
#(
  parameter int ENTRY_W = 70,
  parameter int LANES   = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [LANES-1:0]           push_valid,
  input  logic [LANES*ENTRY_W-1:0]   push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ENTRY_W-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      slot [LANES];
  logic [CW-1:0]      n_push;
  logic               pop_eff;

  assign pop_eff = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Give each valid lane the next free slot so invalid lanes leave no holes
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr + n_push[PW-1:0];
      if (push_valid[i]) n_push = n_push + CW'(1);
    end
  end

  // Storage: contents are don't-care outside [rd_ptr, rd_ptr+count)
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_valid[i]) mem[slot[i]] <= push_data[i*ENTRY_W +: ENTRY_W];
    end
  end

  // Pointer and occupancy update; push and pop may coincide even when full
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop_eff) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + n_push - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: holds one retired bundle for a single cycle,
// drives per-lane RF write/bypass ports with youngest-writer-wins, and
// serialises all valid lanes into the debug trace one per cycle.
module wb_stage_multi
  import wb_stage_multi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          MEM_to_WB_valid,
  input  logic [LANES*lane_wd(DATA_W, ADDR_W)-1:0]      MEM_to_WB_bus,
  output logic                                          WB_allow_in,
  output logic [LANES*rf_lane_wd(DATA_W, ADDR_W)-1:0]   WB_to_RF_bus,
  output logic [DATA_W-1:0]                             debug_wb_pc,
  output logic [DEBUG_WEN_W-1:0]                        debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                             debug_wb_rf_wdata
);

  localparam int LANE_WD    = lane_wd(DATA_W, ADDR_W);
  localparam int RF_LANE_WD = rf_lane_wd(DATA_W, ADDR_W);
  localparam int TRACE_WD   = trace_wd(DATA_W, ADDR_W);
  localparam int CW         = $clog2(TRACE_DEPTH) + 1;

  // Field positions inside a lane (and inside a trace entry, which shares them)
  localparam int DATA_LSB = ADDR_W;
  localparam int PC_LSB   = ADDR_W + DATA_W;
  localparam int WEN_BIT  = ADDR_W + 2 * DATA_W;
  localparam int LV_BIT   = WEN_BIT + 1;

  logic                      wb_valid;
  logic                      wb_ready_go;
  logic [LANES*LANE_WD-1:0]  bundle_q;
  logic                      accept;
  logic                      room_ok;
  logic [CW-1:0]             fifo_count;
  logic [TRACE_WD-1:0]       fifo_head;
  logic [LANES-1:0]          push_valid;
  logic [LANES*TRACE_WD-1:0] push_data;
  logic [LANES-1:0]          byp_valid;
  logic [LANES-1:0]          rf_we;
  logic [LANES-1:0]          lane_wen;
  logic [ADDR_W-1:0]         lane_addr [LANES];
  logic [DATA_W-1:0]         lane_data [LANES];
  int                        room;

  assign wb_ready_go = 1'b1;
  assign WB_allow_in = room_ok & (~wb_valid | wb_ready_go);
  assign accept      = MEM_to_WB_valid & WB_allow_in;

  // Admission assumes a full bundle: free slots plus the slot freed by this cycle's pop
  always_comb begin
    room    = TRACE_DEPTH - int'(fifo_count) + ((fifo_count != '0) ? 1 : 0);
    room_ok = (room >= LANES);
  end

  // Bundle register; WB_valid lasts exactly one cycle per accepted bundle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      bundle_q <= '0;
    end else begin
      wb_valid <= accept;
      if (accept) bundle_q <= MEM_to_WB_bus;
    end
  end

  // Trace pushes come straight from the incoming bus on accept
  always_comb begin
    push_valid = '0;
    push_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      push_valid[i]                      = accept & MEM_to_WB_bus[i*LANE_WD + LV_BIT];
      push_data[i*TRACE_WD +: TRACE_WD] = MEM_to_WB_bus[i*LANE_WD +: TRACE_WD];
    end
  end

  // Per-lane RF ports; an older lane's write is dropped if a younger lane hits the same register
  always_comb begin
    byp_valid    = '0;
    rf_we        = '0;
    lane_wen     = '0;
    WB_to_RF_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = bundle_q[i*LANE_WD +: ADDR_W];
      lane_data[i] = bundle_q[i*LANE_WD + DATA_LSB +: DATA_W];
      lane_wen[i]  = bundle_q[i*LANE_WD + WEN_BIT];
      byp_valid[i] = wb_valid & bundle_q[i*LANE_WD + LV_BIT];
    end
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = byp_valid[i] & lane_wen[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (byp_valid[j] && lane_wen[j] && (lane_addr[j] == lane_addr[i])) rf_we[i] = 1'b0;
      end
      WB_to_RF_bus[i*RF_LANE_WD +: RF_LANE_WD] = {byp_valid[i], rf_we[i], lane_data[i], lane_addr[i]};
    end
  end

  wb_trace_fifo #(
    .ENTRY_W (TRACE_WD),
    .LANES   (LANES),
    .DEPTH   (TRACE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (1'b1),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // Debug trace shows the FIFO head, zeroed while empty
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (fifo_count != '0) begin
      debug_wb_pc       = fifo_head[PC_LSB +: DATA_W];
      debug_wb_rf_wen   = {DEBUG_WEN_W{fifo_head[WEN_BIT]}};
      debug_wb_rf_wnum  = fifo_head[ADDR_W-1:0];
      debug_wb_rf_wdata = fifo_head[DATA_LSB +: DATA_W];
    end
  end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi at default parameters (2 lanes, depth 4).
module tb_wb_stage_multi;

  logic         clk;
  logic         resetn;
  logic         mem_valid;
  logic [141:0] mem_bus;
  logic         allow;
  logic [77:0]  rf_bus;
  logic [31:0]  dbg_pc;
  logic [3:0]   dbg_wen;
  logic [4:0]   dbg_wnum;
  logic [31:0]  dbg_wdata;

  int total = 0;
  int bad   = 0;

  wb_stage_multi dut (
    .clk               (clk),
    .resetn            (resetn),
    .MEM_to_WB_valid   (mem_valid),
    .MEM_to_WB_bus     (mem_bus),
    .WB_allow_in       (allow),
    .WB_to_RF_bus      (rf_bus),
    .debug_wb_pc       (dbg_pc),
    .debug_wb_rf_wen   (dbg_wen),
    .debug_wb_rf_wnum  (dbg_wnum),
    .debug_wb_rf_wdata (dbg_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Occupancy must never exceed the depth
  always @(negedge clk) begin
    if (dut.u_fifo.count > 3'd4) begin
      bad++;
      $display("FAIL count_bound: count=%0d required<=4", dut.u_fifo.count);
    end
  end

  function automatic logic [70:0] mk_lane(input logic v, input logic en, input logic [31:0] pc,
                                          input logic [31:0] data, input logic [4:0] addr);
    return {v, en, pc, data, addr};
  endfunction

  function automatic logic [38:0] rf_lane(input int i);
    return rf_bus[i*39 +: 39];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(1, 1, 32'h1c000004, 32'h22, 5'd4), mk_lane(1, 1, 32'h1c000000, 32'h11, 5'd3)};
    repeat (3) step();
    total++;
    if (allow !== 1'b1) begin bad++; $display("FAIL rst_allow: got %b want 1", allow); end
    total++;
    if ({dbg_wen, dbg_pc} !== 36'h0) begin bad++; $display("FAIL rst_debug: wen=%h pc=%h want 0/0", dbg_wen, dbg_pc); end
    total++;
    if (rf_bus !== 78'h0) begin bad++; $display("FAIL rst_rf: got %h want 0", rf_bus); end
    resetn    = 1'b1;
    mem_valid = 1'b0;
    step();
    total++;
    if ({allow, dbg_wen, rf_lane(0)[37], rf_lane(1)[37]} !== {1'b1, 4'h0, 2'b00})
      begin bad++; $display("FAIL rst_release: allow=%b wen=%h we0=%b we1=%b", allow, dbg_wen, rf_lane(0)[37], rf_lane(1)[37]); end
  endtask

  task automatic test_dual();
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(1, 1, 32'h1c000004, 32'h22, 5'd4), mk_lane(1, 1, 32'h1c000000, 32'h11, 5'd3)};
    step();
    mem_valid = 1'b0;
    total++;
    if (rf_lane(0) !== {2'b11, 32'h11, 5'd3}) begin bad++; $display("FAIL dual_rf0: got %h want %h", rf_lane(0), {2'b11, 32'h11, 5'd3}); end
    total++;
    if (rf_lane(1) !== {2'b11, 32'h22, 5'd4}) begin bad++; $display("FAIL dual_rf1: got %h want %h", rf_lane(1), {2'b11, 32'h22, 5'd4}); end
    total++;
    if ({dbg_pc, dbg_wen, dbg_wnum, dbg_wdata} !== {32'h1c000000, 4'hf, 5'd3, 32'h11})
      begin bad++; $display("FAIL dual_trace0: pc=%h wen=%h wnum=%0d wdata=%h", dbg_pc, dbg_wen, dbg_wnum, dbg_wdata); end
    step();
    total++;
    if ({rf_lane(0)[38:37], rf_lane(1)[38:37]} !== 4'b0000) begin bad++; $display("FAIL dual_once: rf valid bits %b want 0000", {rf_lane(0)[38:37], rf_lane(1)[38:37]}); end
    total++;
    if ({dbg_pc, dbg_wen, dbg_wnum, dbg_wdata} !== {32'h1c000004, 4'hf, 5'd4, 32'h22})
      begin bad++; $display("FAIL dual_trace1: pc=%h wen=%h wnum=%0d wdata=%h", dbg_pc, dbg_wen, dbg_wnum, dbg_wdata); end
    step();
    total++;
    if ({dbg_wen, dbg_pc} !== 36'h0) begin bad++; $display("FAIL dual_empty: wen=%h pc=%h want 0/0", dbg_wen, dbg_pc); end
  endtask

  task automatic test_conflict();
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(1, 1, 32'h104, 32'hB, 5'd5), mk_lane(1, 1, 32'h100, 32'hA, 5'd5)};
    step();
    mem_valid = 1'b0;
    total++;
    if (rf_lane(0)[38:37] !== 2'b10) begin bad++; $display("FAIL conf_lane0: byp/we=%b want 10", rf_lane(0)[38:37]); end
    total++;
    if (rf_lane(1) !== {2'b11, 32'hB, 5'd5}) begin bad++; $display("FAIL conf_lane1: got %h want %h", rf_lane(1), {2'b11, 32'hB, 5'd5}); end
    total++;
    if ({dbg_pc, dbg_wen, dbg_wdata} !== {32'h100, 4'hf, 32'hA}) begin bad++; $display("FAIL conf_trace0: pc=%h wen=%h wdata=%h", dbg_pc, dbg_wen, dbg_wdata); end
    step();
    total++;
    if ({dbg_pc, dbg_wen, dbg_wdata} !== {32'h104, 4'hf, 32'hB}) begin bad++; $display("FAIL conf_trace1: pc=%h wen=%h wdata=%h", dbg_pc, dbg_wen, dbg_wdata); end
    step();
  endtask

  task automatic test_backpressure();
    int          mc;
    int          sent;
    int          cyc;
    logic        exp_allow;
    logic        acc;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [63:0] q[$];
    mc   = 0;
    sent = 0;
    for (cyc = 0; cyc < 300 && !(sent == 20 && mc == 0); cyc++) begin
      exp_allow = ((4 - mc + ((mc > 0) ? 1 : 0)) >= 2);
      total++;
      if (allow !== exp_allow) begin bad++; $display("FAIL bp_allow cyc %0d: got %b want %b", cyc, allow, exp_allow); end
      total++;
      if (mc > 0) begin
        if ({dbg_wen, dbg_pc, dbg_wdata} !== {4'hf, q[0]})
          begin bad++; $display("FAIL bp_trace cyc %0d: wen=%h pc=%h wdata=%h want pc/wdata %h", cyc, dbg_wen, dbg_pc, dbg_wdata, q[0]); end
      end else if (dbg_wen !== 4'h0) begin
        bad++; $display("FAIL bp_empty cyc %0d: wen=%h want 0", cyc, dbg_wen);
      end
      pc0 = 32'h1c001000 + 32'(sent * 8);
      pc1 = pc0 + 32'h4;
      d0  = 32'(sent * 16);
      d1  = d0 + 32'h1;
      mem_valid = (sent < 20);
      mem_bus   = {mk_lane(1, 1, pc1, d1, 5'((2 * sent + 1) % 31 + 1)), mk_lane(1, 1, pc0, d0, 5'((2 * sent) % 31 + 1))};
      acc = mem_valid && exp_allow;
      if (mc > 0) begin
        void'(q.pop_front());
        mc--;
      end
      if (acc) begin
        q.push_back({pc0, d0});
        q.push_back({pc1, d1});
        mc += 2;
        sent++;
      end
      step();
    end
    mem_valid = 1'b0;
    total++;
    if (!(sent == 20 && mc == 0)) begin bad++; $display("FAIL bp_timeout: sent=%0d pending=%0d want 20/0", sent, mc); end
  endtask

  task automatic test_partial();
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(0, 1, 32'h3000, 32'h99, 5'd7), mk_lane(1, 0, 32'h2000, 32'h55, 5'd7)};
    step();
    mem_valid = 1'b0;
    total++;
    if (rf_lane(0) !== {2'b10, 32'h55, 5'd7}) begin bad++; $display("FAIL part_rf0: got %h want %h", rf_lane(0), {2'b10, 32'h55, 5'd7}); end
    total++;
    if (rf_lane(1)[38:37] !== 2'b00) begin bad++; $display("FAIL part_rf1: byp/we=%b want 00", rf_lane(1)[38:37]); end
    total++;
    if ({dbg_pc, dbg_wen, dbg_wnum, dbg_wdata} !== {32'h2000, 4'h0, 5'd7, 32'h55})
      begin bad++; $display("FAIL part_trace: pc=%h wen=%h wnum=%0d wdata=%h", dbg_pc, dbg_wen, dbg_wnum, dbg_wdata); end
    step();
    total++;
    if ({dbg_pc, dbg_wen} !== 36'h0) begin bad++; $display("FAIL part_single: pc=%h wen=%h want 0/0", dbg_pc, dbg_wen); end
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(0, 1, 32'h4004, 32'h1, 5'd9), mk_lane(0, 1, 32'h4000, 32'h2, 5'd9)};
    step();
    mem_valid = 1'b0;
    total++;
    if ({rf_lane(0)[38:37], rf_lane(1)[38:37], dbg_pc, dbg_wen} !== 40'h0)
      begin bad++; $display("FAIL empty_bundle: rfbits=%b pc=%h wen=%h", {rf_lane(0)[38:37], rf_lane(1)[38:37]}, dbg_pc, dbg_wen); end
  endtask

  task automatic test_reset_mid_drain();
    mem_valid = 1'b1;
    mem_bus   = {mk_lane(1, 1, 32'h5004, 32'h2, 5'd2), mk_lane(1, 1, 32'h5000, 32'h1, 5'd1)};
    step();
    mem_bus   = {mk_lane(1, 1, 32'h500c, 32'h4, 5'd4), mk_lane(1, 1, 32'h5008, 32'h3, 5'd3)};
    step();
    mem_valid = 1'b0;
    total++;
    if ({dbg_pc, dbg_wen} !== {32'h5004, 4'hf}) begin bad++; $display("FAIL mid_head: pc=%h wen=%h want 5004/f", dbg_pc, dbg_wen); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    total++;
    if ({allow, dbg_pc, dbg_wen} !== {1'b1, 36'h0}) begin bad++; $display("FAIL mid_reset: allow=%b pc=%h wen=%h", allow, dbg_pc, dbg_wen); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({dbg_pc, dbg_wen} !== 36'h0) begin bad++; $display("FAIL mid_stale %0d: pc=%h wen=%h want 0/0", k, dbg_pc, dbg_wen); end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_bus   = '0;
    test_reset();
    test_dual();
    test_conflict();
    test_backpressure();
    test_partial();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage_multi.md
Name: wb_stage_multi

Overview:
Parametrised successor to the single-lane writeback stage.
- Retires a bundle of up to LANES results per cycle from MEM.
- Drives LANES register-file write/bypass ports, with program-order conflict resolution.
- Serialises every retired lane through a trace FIFO, so the debug trace interface emits exactly one retirement per cycle in program order.
- Sits between MEM_stage and the register file in the dual-issue core.

Parameters:
DATA_W, 32, register/PC data width
ADDR_W, 5, register address width
LANES, 2, write lanes per bundle; lane 0 is the oldest instruction
TRACE_DEPTH, 4, trace FIFO entries; must be a power of two and >= LANES
LANE_WD, 2+2*DATA_W+ADDR_W, per-lane bus width (71 at defaults); derived, not overridable

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
MEM_to_WB_valid  in  1  bundle valid from MEM
MEM_to_WB_bus  in  LANES*LANE_WD  per lane i at [i*LANE_WD +: LANE_WD]: {lane_valid, w_en, pc[DATA_W], w_data[DATA_W], w_addr[ADDR_W]}, MSB first
WB_allow_in  out  1  WB can accept a bundle this cycle
WB_to_RF_bus  out  LANES*(2+DATA_W+ADDR_W)  per lane: {byp_valid, rf_we, w_data, w_addr}
debug_wb_pc  out  DATA_W  PC of the retirement at the trace FIFO head
debug_wb_rf_wen  out  4  {4{head.w_en}} when the FIFO is non-empty, else 0
debug_wb_rf_wnum  out  ADDR_W  head write address
debug_wb_rf_wdata  out  DATA_W  head write data

Behaviour:
- Reset is synchronous: on the clk edge with resetn=0, all of the following are cleared: WB_valid=0, FIFO count=0, read/write pointers=0, bundle register=0. All debug outputs read 0; WB_to_RF_bus is all-zero.
- WB_ready_go is fixed at 1. accept = MEM_to_WB_valid & WB_allow_in.
  - On accept, the bundle register loads MEM_to_WB_bus.
  - Every edge, WB_valid <= accept. A bundle therefore occupies WB for exactly one cycle and is never written to the RF twice.
- RF lane i:
  - byp_valid = WB_valid & lane_valid[i].
  - rf_we = byp_valid & w_en[i] & ~(some younger lane j>i with byp_valid & w_en & w_addr equal to lane i's).
  - The youngest writer wins. w_addr==0 is passed through unchanged; the RF ignores r0.
- Trace FIFO push:
  - On accept, every lane with lane_valid=1 is written in lane order at wr_ptr, wr_ptr+1, ... (mod TRACE_DEPTH).
  - Lanes with w_en=0 are pushed too, so the PC trace stays complete.
  - A bundle with zero valid lanes pushes nothing.
- Trace FIFO pop: one entry per cycle whenever count>0. The debug outputs are combinational from the head entry.
- count_next = count + pushes - pop. Simultaneous push and pop is legal, including when count==TRACE_DEPTH and the pop frees the slot.
- WB_allow_in = (TRACE_DEPTH - count + (count>0)) >= LANES. This is conservative: it does not depend on how many lanes in the incoming bundle are valid.
- Pointers are $clog2(TRACE_DEPTH) bits and wrap naturally. count is $clog2(TRACE_DEPTH)+1 bits.
- Overflow is impossible by construction. The verification bench asserts count <= TRACE_DEPTH every cycle.
- When resetn=0 arrives mid-drain, FIFO contents are discarded and no further debug entries appear.
- Latency: RF write one cycle after accept. A lane's first debug appearance is one cycle after accept if the FIFO was empty; otherwise it follows FIFO order.

Decomposition:
- myCPU.h gains `WB_LANES, `LANE_WD, `WB_TO_RF_LANE_WD and a bus field-offset macro.
- `MEM_TO_WB_BUS_WD becomes `WB_LANES*`LANE_WD.
- Sub-module wb_trace_fifo: multi-push (up to LANES), single-pop, power-of-two circular buffer exposing count/head. The stage owns the handshake and conflict logic.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles while MEM_to_WB_valid=1 -> WB_allow_in=1 after release, debug_wb_rf_wen=0, all rf_we=0.
2. Single dual bundle: lane0 {pc=0x1c000000, $3<=0x11}, lane1 {pc=0x1c000004, $4<=0x22}
   - -> next cycle: both rf_we=1.
   - -> debug shows 0x1c000000/$3/0x11, then 0x1c000004/$4/0x22 on consecutive cycles, then wen=0.
3. Same-address conflict: lane0 $5<=0xA, lane1 $5<=0xB -> lane0 rf_we=0, lane1 rf_we=1 with 0xB; both entries still appear in the trace.
4. Backpressure: MEM_to_WB_valid=1 with full dual bundles every cycle (DEPTH=4) -> WB_allow_in toggles; a steady state of one bundle every 2 cycles; no trace entry lost or reordered across 20 bundles and pointer wrap.
5. Partial bundle: lane_valid={0,1}, w_en=0 for lane0 -> one FIFO entry, debug_wb_rf_wen=0 with the correct PC, byp_valid=1 for lane0 only.
6. Reset mid-drain: 3 entries queued, resetn=0 for one cycle -> count=0, debug wen=0 thereafter, no stale PC emitted.
